stream_mux_n: RTL and testbench

Parametrised N-channel, W-bit streaming multiplexer with valid/ready handshakes on every input and on the output, and a one-entry registered output stage. It generalises the lab's combinational 4:1 select to any channel count and data width. It adds a run-time choice between externally selected and round-robin arbitration, and it reports which channel produced each output word. It sits between several producer blocks and a single consumer in the lab datapath.

---
 rtl/stream_mux_n_if.sv | 38 +++
 rtl/stream_mux_n.sv | 113 +++++++++++
 tb/tb_stream_mux_n.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/stream_mux_n_if.sv
// stream_mux_n_if: bundles the streaming handshake and select signals of the
// N-channel stream multiplexer.
//   in_data   : N*W packed channel words, channel i at [i*W +: W]
//   in_valid  : per-channel valid
//   in_ready  : per-channel ready, driven by the multiplexer
//   sel       : fixed-mode channel select
//   rr_en     : 1 = round-robin arbitration, 0 = fixed select
//   out_data  : registered output word
//   out_chan  : index of the channel that supplied out_data
//   out_valid : output word valid
//   out_ready : consumer ready
// master = producers/consumer side, slave = the multiplexer.
interface stream_mux_n_if #(
    parameter int N = 4,
    parameter int W = 8
);
    localparam int SW = $clog2(N);

    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [SW-1:0]  sel;
    logic           rr_en;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_chan;
    logic           out_valid;
    logic           out_ready;

    modport master (
        output in_data, in_valid, sel, rr_en, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );

    modport slave (
        input  in_data, in_valid, sel, rr_en, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );
endinterface

// File: rtl/stream_mux_n.sv
// stream_mux_n: N-channel, W-bit valid/ready stream multiplexer with a
// one-entry registered output stage. The grant is either the externally
// supplied sel (rr_en = 0) or a round-robin search starting at ptr
// (rr_en = 1). The output reports which channel supplied each word.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   sif   : stream_mux_n_if slave modport (all handshake/data signals)
module stream_mux_n #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    stream_mux_n_if.slave  sif
);
    localparam int SW = $clog2(N);

    logic [W-1:0]  r_out_data;
    logic [SW-1:0] r_out_chan;
    logic          r_out_valid;
    logic [SW-1:0] r_ptr;

    logic          w_load;
    logic [SW-1:0] w_gnt;
    logic          w_gv;
    logic          w_hs;
    logic [W-1:0]  w_data;
    logic [N-1:0]  w_ready;

    // Channel index reached by stepping 'off' places from 'base', wrapping at N
    // (not at 2^SW, so non-power-of-two channel counts work).
    function automatic logic [SW-1:0] rr_index(input logic [SW-1:0] base, input int off);
        int t;
        t = int'(base) + off;
        if (t >= N) begin
            t = t - N;
        end else begin
            t = t;
        end
        return SW'(t);
    endfunction

    assign w_load = !r_out_valid || sif.out_ready;
    assign w_hs   = w_load && w_gv;

    // Grant selection: fixed select or round-robin search from ptr.
    always_comb begin
        w_gnt = '0;
        w_gv  = 1'b0;
        if (sif.rr_en) begin
            w_gv = |sif.in_valid;
            // Walk from the far end back to ptr so the closest valid
            // channel (smallest offset) wins.
            for (int k = N - 1; k >= 0; k--) begin
                w_gnt = sif.in_valid[rr_index(r_ptr, k)] ? rr_index(r_ptr, k) : w_gnt;
            end
        end else begin
            w_gnt = sif.sel;
            if (32'(sif.sel) < N) begin
                w_gv = sif.in_valid[sif.sel];
            end else begin
                w_gv = 1'b0;
            end
        end
    end

    // Data mux and one-hot ready generation from the grant.
    always_comb begin
        w_data  = '0;
        w_ready = '0;
        for (int i = 0; i < N; i++) begin
            if (w_gnt == SW'(i)) begin
                w_data     = sif.in_data[i*W +: W];
                w_ready[i] = w_hs;
            end else begin
                w_ready[i] = 1'b0;
            end
        end
    end

    // Output register stage and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_out_valid <= 1'b0;
            r_ptr       <= '0;
        end else begin
            if (w_load) begin
                if (w_gv) begin
                    r_out_data  <= w_data;
                    r_out_chan  <= w_gnt;
                    r_out_valid <= 1'b1;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end else begin
                r_out_valid <= r_out_valid;
            end
            // Only round-robin handshakes advance the pointer.
            if (w_hs && sif.rr_en) begin
                r_ptr <= (w_gnt == SW'(N - 1)) ? '0 : w_gnt + SW'(1);
            end else begin
                r_ptr <= r_ptr;
            end
        end
    end

    assign sif.in_ready  = w_ready;
    assign sif.out_data  = r_out_data;
    assign sif.out_chan  = r_out_chan;
    assign sif.out_valid = r_out_valid;
endmodule

// File: tb/tb_stream_mux_n.sv
// tb_stream_mux_n: directed bench for stream_mux_n (N = 5, W = 8).
// The driver pushes the expected {data, chan} of every expected input
// handshake into a scoreboard queue; a monitor pops and compares whenever the
// DUT hands a word to the consumer.
module tb_stream_mux_n;
    localparam int N  = 5;
    localparam int W  = 8;
    localparam int SW = $clog2(N);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stream_mux_n_if #(.N(N), .W(W)) sif ();

    stream_mux_n #(.N(N), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sif   (sif)
    );

    int checks = 0;
    int errors = 0;
    logic [W+SW-1:0] sb[$];
    logic [W-1:0]    chan_data[N];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every consumed output word must match the scoreboard head.
    always @(negedge clk) begin : monitor
        logic [W+SW-1:0] exp_w;
        if (rst_n && sif.out_valid && sif.out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_word: got %0h expected no word", {sif.out_data, sif.out_chan});
            end else begin
                exp_w = sb.pop_front();
                check("out_word", 32'({sif.out_data, sif.out_chan}), 32'(exp_w));
            end
        end
    end

    // One cycle: drive inputs, check ready/valid mid-cycle, record expected words.
    task automatic step(input logic [N-1:0] v, input logic [SW-1:0] s, input logic rr,
                        input logic ordy, input logic [N-1:0] exp_rdy, input int exp_ov,
                        input string tag);
        for (int i = 0; i < N; i++) sif.in_data[i*W +: W] = chan_data[i];
        sif.in_valid  = v;
        sif.sel       = s;
        sif.rr_en     = rr;
        sif.out_ready = ordy;
        @(negedge clk);
        check({tag, " in_ready"}, 32'(sif.in_ready), 32'(exp_rdy));
        if (exp_ov >= 0) check({tag, " out_valid"}, 32'(sif.out_valid), 32'(exp_ov));
        for (int i = 0; i < N; i++) begin
            if (exp_rdy[i]) sb.push_back({chan_data[i], SW'(i)});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        for (int i = 0; i < N; i++) chan_data[i] = 8'h00;
        sif.in_data   = '0;
        sif.in_valid  = '0;
        sif.sel       = '0;
        sif.rr_en     = 1'b0;
        sif.out_ready = 1'b0;
        #12;
        check("rst out_valid", 32'(sif.out_valid), 32'd0);
        check("rst out_data", 32'(sif.out_data), 32'd0);
        check("rst out_chan", 32'(sif.out_chan), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fixed select of channel 2.
        chan_data[2] = 8'hA5;
        step(5'b00100, 3'd2, 1'b0, 1'b1, 5'b00100, 0, "t1");
        check("t1 out_data", 32'(sif.out_data), 32'hA5);
        check("t1 out_chan", 32'(sif.out_chan), 32'd2);
        step(5'b00000, 3'd2, 1'b0, 1'b1, 5'b00000, 1, "t1b");

        // Round-robin fairness, all channels valid: 0,1,2,3,4,0 back to back.
        for (int i = 0; i < N; i++) chan_data[i] = 8'h10 + 8'(i);
        for (int k = 0; k < 6; k++) begin
            step(5'b11111, 3'd0, 1'b1, 1'b1, 5'(5'b00001 << (k % N)), (k == 0) ? 0 : 1, "rr");
        end
        step(5'b00000, 3'd0, 1'b1, 1'b1, 5'b00000, 1, "rr_end");

        // Backpressure: 3C held for 5 cycles, then consume and reload with no bubble.
        chan_data[1] = 8'h3C;
        step(5'b00010, 3'd1, 1'b0, 1'b1, 5'b00010, 0, "bp_load");
        for (int k = 0; k < 5; k++) begin
            step(5'b00010, 3'd1, 1'b0, 1'b0, 5'b00000, 1, "bp_hold");
            check("bp out_data", 32'(sif.out_data), 32'h3C);
            check("bp out_chan", 32'(sif.out_chan), 32'd1);
        end
        chan_data[1] = 8'h3D;
        step(5'b00010, 3'd1, 1'b0, 1'b1, 5'b00010, 1, "bp_go");
        step(5'b00000, 3'd1, 1'b0, 1'b1, 5'b00000, 1, "bp_drain");
        step(5'b00000, 3'd1, 1'b0, 1'b1, 5'b00000, 0, "bp_empty");

        // Wrap and skip: ptr is 1 here; ch3 grant sets ptr = 4, then 0 (wrap), then 2.
        for (int i = 0; i < N; i++) chan_data[i] = 8'h20 + 8'(i);
        step(5'b01000, 3'd0, 1'b1, 1'b1, 5'b01000, 0, "wrap_ch3");
        step(5'b00101, 3'd0, 1'b1, 1'b1, 5'b00001, 1, "wrap_ch0");
        step(5'b00101, 3'd0, 1'b1, 1'b1, 5'b00100, 1, "skip_ch2");

        // Out-of-range select: nothing granted, output drains to empty.
        step(5'b11111, 3'd5, 1'b0, 1'b1, 5'b00000, 1, "badsel");
        step(5'b11111, 3'd5, 1'b0, 1'b1, 5'b00000, 0, "badsel_empty");

        // Async reset while a word is pending (ptr = 3 -> ch3 granted first).
        step(5'b11111, 3'd0, 1'b1, 1'b1, 5'b01000, 0, "pre_rst");
        check("pre_rst out_valid", 32'(sif.out_valid), 32'd1);
        sif.in_valid  = '0;
        sif.out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async out_valid", 32'(sif.out_valid), 32'd0);
        check("async out_data", 32'(sif.out_data), 32'd0);
        check("async out_chan", 32'(sif.out_chan), 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(5'b11111, 3'd0, 1'b1, 1'b1, 5'b00001, 0, "post_rst");
        step(5'b00000, 3'd0, 1'b1, 1'b1, 5'b00000, 1, "post_drain");
        step(5'b00000, 3'd0, 1'b1, 1'b1, 5'b00000, 0, "post_empty");

        check("sb empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
